multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Sequencing controller for the multi-cycle RV32I core: a Moore/Mealy FSM that walks each instruction through IF, ID, EX, MEM and WB, and drives the shared ALU's operand selects and operation mode. It drives PC, IR and register-file write enables and the memory request. It sits beside the ALU control decoder: the decoder produces the final ALU op only when this block requests instruction-based decode. The block also stalls on a memory ready handshake and halts on ECALL.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0]
- bcond  in  1  ALU branch-compare result, valid in EX of a branch
- halt_req  in  1  high when x17 == 10, evaluated outside this block
- mem_ready  in  1  memory completes the current request this cycle
- pc_write, ir_write, reg_write  out  1  write enables
- mem_read, mem_write  out  1  memory request, held until mem_ready
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- alu_src_a  out  1  0 = PC, 1 = A register
- alu_src_b  out  2  0 = B register, 1 = constant 4, 2 = immediate
- alu_mode  out  2  0 = force add, 1 = decode funct3/funct7, 2 = branch compare
- pc_source  out  1  0 = live ALU result, 1 = ALUOut
- wb_sel  out  1  0 = ALUOut, 1 = MDR
- is_halted  out  1  core stopped
- retired  out  CNT_W  instructions completed

## Operation
- Outputs not listed for a state are 0.
- **IF:**
  - Drives mem_read=1, i_or_d=0.
  - On mem_ready: ir_write=1, go to ID.
  - Otherwise stay in IF.
- **ID:**
  - Drives src_a=PC, src_b=4, mode=add; ALUOut latches PC+4.
  - ECALL with halt_req: go to HALT.
  - ECALL without halt_req, or unknown opcode: pc_write=1, pc_source=0, go to IF.
  - Otherwise go to EX.
- **EX:**
  - R-type: src_a=A, src_b=B, mode=decode, go to WB.
  - I-arith: src_a=A, src_b=imm, mode=decode, go to WB.
  - LOAD/STORE: src_a=A, src_b=imm, mode=add, go to MEM.
  - BRANCH: src_a=A, src_b=B, mode=branch.
    - bcond=1: go to BR.
    - bcond=0: pc_write=1, pc_source=1 (PC+4), go to IF.
  - JAL: src_a=PC, src_b=imm, mode=add.
    - JALR uses the same outputs except src_a=A.
    - Both drive reg_write=1, wb_sel=0 (rd ← PC+4 held in ALUOut), pc_write=1, pc_source=0, go to IF.
- **BR:** src_a=PC, src_b=imm, mode=add, pc_write=1, pc_source=0, go to IF.
- **MEM:**
  - Drives i_or_d=1.
  - LOAD: mem_read=1; on mem_ready go to WB.
  - STORE: mem_write=1; on mem_ready also drive src_a=PC, src_b=4, mode=add, pc_write=1, pc_source=0, and go to IF.
- **WB:**
  - Drives reg_write=1; wb_sel=1 for LOAD, else 0.
  - Drives src_a=PC, src_b=4, mode=add, pc_write=1, pc_source=0.
  - Go to IF.
- **HALT:**
  - is_halted=1; all other outputs 0.
  - No exit except reset.
  - mem_ready and opcode are ignored.
- **retired counter:**
  - Increments by 1 in every cycle where pc_write=1, and on entry to HALT.
  - Wraps modulo 2^CNT_W.
- pc_write and reg_write are never asserted in IF or HALT.

## Timing
- **Reset:**
  - reset_n low forces state=IF and retired=0 immediately, regardless of clock; this also applies mid-instruction.
  - Combinational outputs follow, so mem_read=1 and i_or_d=0 during and after reset.
  - Every other output is 0.
- **State and outputs:**
  - State is registered.
  - Outputs are combinational from state, opcode, bcond, halt_req and mem_ready.
  - Enables depending on mem_ready or bcond are Mealy and valid in the same cycle.
- **mem_ready handshake:**
  - Zero-wait memory (mem_ready high in the first request cycle) is legal.
  - mem_read/mem_write and i_or_d stay constant while waiting.
  - mem_ready outside IF/MEM is ignored.
- **Latency with zero-wait memory:**
  - Cycles: R/I-arith 4, LOAD 5, STORE 4, branch not taken 3, taken 4, JAL/JALR 3, non-halting ECALL 2.
  - Each memory wait cycle adds 1.
- opcode is sampled only in ID through MEM/WB; IR is stable after the IF→ID edge.

## Structure
- State encodings (IF, ID, EX, MEM, WB, BR, HALT, 3 bits) go in a shared control-defines header.
- Select/mode encodings for alu_src_b, alu_mode, pc_source and wb_sel go in the same header, because the datapath muxes and the ALU control decoder consume them.
- Opcode constants come from the existing opcodes header.
- Flat single module; no sub-module. The retire counter is one always block.

## Test plan
- **Reset:** reset_n low mid-EX → same-cycle state=IF, retired=0, mem_read=1, i_or_d=0.
- **Back-to-back instructions:** add, zero-wait memory → IF, ID, EX, WB; in WB reg_write=1, pc_write=1, wb_sel=0.
  - Next: lw, memory with 2 wait cycles → MEM lasts 3 cycles with mem_read=1, i_or_d=1; WB wb_sel=1; retired=2.
- **beq, bcond=0:** exits after EX, pc_source=1, 3 cycles.
- **beq, bcond=1:** enters BR, pc_source=0, src_b=2, 4 cycles.
- **jalr:** in EX reg_write=1, pc_write=1, src_a=1, wb_sel=0, same cycle; next state IF.
- **ECALL:**
  - halt_req=1 → HALT with is_halted=1; mem_ready pulses are ignored; retired increments once and then freezes.
  - halt_req=0 → pc_write in ID, back to IF.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared control encodings for the multi-cycle RV32I core: FSM states, datapath mux selects,
// ALU mode requests and the base opcodes the sequencer dispatches on.
package multicycle_control_fsm_pkg;

  localparam logic [2:0] StIf   = 3'd0;
  localparam logic [2:0] StId   = 3'd1;
  localparam logic [2:0] StEx   = 3'd2;
  localparam logic [2:0] StMem  = 3'd3;
  localparam logic [2:0] StWb   = 3'd4;
  localparam logic [2:0] StBr   = 3'd5;
  localparam logic [2:0] StHalt = 3'd6;

  localparam logic       SrcAPc  = 1'b0;
  localparam logic       SrcAReg = 1'b1;

  localparam logic [1:0] SrcBReg  = 2'd0;
  localparam logic [1:0] SrcBFour = 2'd1;
  localparam logic [1:0] SrcBImm  = 2'd2;

  // The ALU control decoder only looks at funct3/funct7 when AluDecode is requested.
  localparam logic [1:0] AluAdd    = 2'd0;
  localparam logic [1:0] AluDecode = 2'd1;
  localparam logic [1:0] AluBranch = 2'd2;

  localparam logic       PcSrcAlu    = 1'b0;
  localparam logic       PcSrcAluOut = 1'b1;

  localparam logic       WbAluOut = 1'b0;
  localparam logic       WbMdr    = 1'b1;

  localparam logic       AddrPc     = 1'b0;
  localparam logic       AddrAluOut = 1'b1;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_mode;
    logic       pc_source;
    logic       wb_sel;
    logic       is_halted;
  } ctrl_t;

  // Opcodes that have an EX state; everything else is retired as a no-op from ID.
  function automatic logic has_ex_stage(input logic [6:0] op);
    case (op)
      OpLoad, OpImm, OpStore, OpReg, OpBranch, OpJalr, OpJal: has_ex_stage = 1'b1;
      default:                                                has_ex_stage = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the sequencer (master) and the datapath/memory side (slave).
interface multicycle_control_fsm_if #(
  parameter int unsigned CNT_W = 32
);

  logic [6:0]       opcode;
  logic             bcond;
  logic             halt_req;
  logic             mem_ready;

  logic             pc_write;
  logic             ir_write;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic             i_or_d;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_mode;
  logic             pc_source;
  logic             wb_sel;
  logic             is_halted;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, bcond, halt_req, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d,
    output alu_src_a, alu_src_b, alu_mode, pc_source, wb_sel, is_halted, retired
  );

  modport slave (
    output opcode, bcond, halt_req, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d,
    input  alu_src_a, alu_src_b, alu_mode, pc_source, wb_sel, is_halted, retired
  );

endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: IF/ID/EX/MEM/WB/BR/HALT with registered state and
// combinational (partly Mealy) datapath controls, plus a retired-instruction counter.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  multicycle_control_fsm_if.master  bus
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             halt_entry;
  ctrl_t            ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIf;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    ctrl       = '0;
    state_d    = state_q;
    halt_entry = 1'b0;

    case (state_q)
      StIf: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = AddrPc;
        if (bus.mem_ready) begin
          ctrl.ir_write = 1'b1;
          state_d       = StId;
        end
      end

      StId: begin
        // ALUOut captures PC+4 here for later link/advance use.
        ctrl.alu_src_a = SrcAPc;
        ctrl.alu_src_b = SrcBFour;
        ctrl.alu_mode  = AluAdd;
        if (bus.opcode == OpSystem && bus.halt_req) begin
          halt_entry = 1'b1;
          state_d    = StHalt;
        end else if (bus.opcode == OpSystem || !has_ex_stage(bus.opcode)) begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PcSrcAlu;
          state_d        = StIf;
        end else begin
          state_d = StEx;
        end
      end

      StEx: begin
        case (bus.opcode)
          OpReg: begin
            ctrl.alu_src_a = SrcAReg;
            ctrl.alu_src_b = SrcBReg;
            ctrl.alu_mode  = AluDecode;
            state_d        = StWb;
          end
          OpImm: begin
            ctrl.alu_src_a = SrcAReg;
            ctrl.alu_src_b = SrcBImm;
            ctrl.alu_mode  = AluDecode;
            state_d        = StWb;
          end
          OpLoad, OpStore: begin
            ctrl.alu_src_a = SrcAReg;
            ctrl.alu_src_b = SrcBImm;
            ctrl.alu_mode  = AluAdd;
            state_d        = StMem;
          end
          OpBranch: begin
            ctrl.alu_src_a = SrcAReg;
            ctrl.alu_src_b = SrcBReg;
            ctrl.alu_mode  = AluBranch;
            if (bus.bcond) begin
              state_d = StBr;
            end else begin
              // Not taken: PC+4 is still sitting in ALUOut from ID.
              ctrl.pc_write  = 1'b1;
              ctrl.pc_source = PcSrcAluOut;
              state_d        = StIf;
            end
          end
          OpJal, OpJalr: begin
            ctrl.alu_src_a = (bus.opcode == OpJalr) ? SrcAReg : SrcAPc;
            ctrl.alu_src_b = SrcBImm;
            ctrl.alu_mode  = AluAdd;
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = WbAluOut;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PcSrcAlu;
            state_d        = StIf;
          end
          default: state_d = StIf;
        endcase
      end

      StBr: begin
        ctrl.alu_src_a = SrcAPc;
        ctrl.alu_src_b = SrcBImm;
        ctrl.alu_mode  = AluAdd;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PcSrcAlu;
        state_d        = StIf;
      end

      StMem: begin
        ctrl.i_or_d = AddrAluOut;
        if (bus.opcode == OpStore) begin
          ctrl.mem_write = 1'b1;
          if (bus.mem_ready) begin
            ctrl.alu_src_a = SrcAPc;
            ctrl.alu_src_b = SrcBFour;
            ctrl.alu_mode  = AluAdd;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PcSrcAlu;
            state_d        = StIf;
          end
        end else begin
          ctrl.mem_read = 1'b1;
          if (bus.mem_ready) begin
            state_d = StWb;
          end
        end
      end

      StWb: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = (bus.opcode == OpLoad) ? WbMdr : WbAluOut;
        ctrl.alu_src_a = SrcAPc;
        ctrl.alu_src_b = SrcBFour;
        ctrl.alu_mode  = AluAdd;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PcSrcAlu;
        state_d        = StIf;
      end

      StHalt: begin
        ctrl.is_halted = 1'b1;
      end

      default: state_d = StIf;
    endcase
  end

  // Every instruction retires through exactly one PC write, except a halting ECALL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= '0;
    end else if (ctrl.pc_write || halt_entry) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.pc_write  = ctrl.pc_write;
  assign bus.ir_write  = ctrl.ir_write;
  assign bus.reg_write = ctrl.reg_write;
  assign bus.mem_read  = ctrl.mem_read;
  assign bus.mem_write = ctrl.mem_write;
  assign bus.i_or_d    = ctrl.i_or_d;
  assign bus.alu_src_a = ctrl.alu_src_a;
  assign bus.alu_src_b = ctrl.alu_src_b;
  assign bus.alu_mode  = ctrl.alu_mode;
  assign bus.pc_source = ctrl.pc_source;
  assign bus.wb_sel    = ctrl.wb_sel;
  assign bus.is_halted = ctrl.is_halted;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboarded bench for the multi-cycle sequencer: per-cycle stimulus and expected control
// vectors are queued per scenario, then replayed and compared cycle by cycle.
module tb_multicycle_control_fsm;

  localparam int unsigned CNT_W = 32;

  localparam logic [6:0] OpR    = 7'h33;
  localparam logic [6:0] OpI    = 7'h13;
  localparam logic [6:0] OpLd   = 7'h03;
  localparam logic [6:0] OpSt   = 7'h23;
  localparam logic [6:0] OpBr   = 7'h63;
  localparam logic [6:0] OpJal  = 7'h6f;
  localparam logic [6:0] OpJalr = 7'h67;
  localparam logic [6:0] OpSys  = 7'h73;
  localparam logic [6:0] OpLui  = 7'h37;

  // Vector layout: pc_write ir_write reg_write mem_read mem_write i_or_d src_a src_b[1:0]
  //                mode[1:0] pc_source wb_sel is_halted
  function automatic logic [13:0] ev(input logic pcw, input logic irw, input logic rw,
                                     input logic mr, input logic mw, input logic iod,
                                     input logic sa, input logic [1:0] sb, input logic [1:0] am,
                                     input logic ps, input logic wb, input logic hal);
    return {pcw, irw, rw, mr, mw, iod, sa, sb, am, ps, wb, hal};
  endfunction

  localparam logic [13:0] EIfWait    = ev(0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0);
  localparam logic [13:0] EIfRdy     = ev(0, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0);
  localparam logic [13:0] EId        = ev(0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 0, 0, 0);
  localparam logic [13:0] EIdSkip    = ev(1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 0, 0, 0);
  localparam logic [13:0] EExR       = ev(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 0, 0, 0);
  localparam logic [13:0] EExI       = ev(0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd1, 0, 0, 0);
  localparam logic [13:0] EExMem     = ev(0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0, 0, 0);
  localparam logic [13:0] EExBrNt    = ev(1, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 1, 0, 0);
  localparam logic [13:0] EExBrT     = ev(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 0, 0, 0);
  localparam logic [13:0] EBr        = ev(1, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 0, 0, 0);
  localparam logic [13:0] EExJal     = ev(1, 0, 1, 0, 0, 0, 0, 2'd2, 2'd0, 0, 0, 0);
  localparam logic [13:0] EExJalr    = ev(1, 0, 1, 0, 0, 0, 1, 2'd2, 2'd0, 0, 0, 0);
  localparam logic [13:0] EMemLd     = ev(0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 0, 0);
  localparam logic [13:0] EMemStWait = ev(0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 0, 0, 0);
  localparam logic [13:0] EMemStRdy  = ev(1, 0, 0, 0, 1, 1, 0, 2'd1, 2'd0, 0, 0, 0);
  localparam logic [13:0] EWbAlu     = ev(1, 0, 1, 0, 0, 0, 0, 2'd1, 2'd0, 0, 0, 0);
  localparam logic [13:0] EWbMdr     = ev(1, 0, 1, 0, 0, 0, 0, 2'd1, 2'd0, 0, 1, 0);
  localparam logic [13:0] EHalt      = ev(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 1);

  typedef struct packed {
    logic [6:0] op;
    logic       bc;
    logic       hr;
    logic       mr;
  } stim_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  wire [13:0] obs = {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read, bus.mem_write,
                     bus.i_or_d, bus.alu_src_a, bus.alu_src_b, bus.alu_mode, bus.pc_source,
                     bus.wb_sel, bus.is_halted};

  stim_t            stim_q[$];
  logic [13:0]      exp_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_retired = '0;

  task automatic push(input logic [6:0] op, input logic bc, input logic hr, input logic mr,
                      input logic [13:0] e);
    stim_q.push_back(stim_t'{op, bc, hr, mr});
    exp_q.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    bus.opcode    = s.op;
    bus.bcond     = s.bc;
    bus.halt_req  = s.hr;
    bus.mem_ready = s.mr;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    apply(stim_t'{OpR, 1'b0, 1'b0, 1'b0});
    #2;
    checks++;
    if (obs !== EIfWait) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", obs, EIfWait);
    end
    checks++;
    if (bus.retired !== '0) begin
      errors++;
      $display("FAIL reset_retired got %0d want 0", bus.retired);
    end
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    stim_t s;
    logic [13:0] e;
    int n = 0;
    push(OpR, 0, 0, 1, EIfRdy);
    push(OpR, 0, 0, 1, EId);      // mem_ready outside IF/MEM must be ignored
    push(OpR, 0, 0, 1, EExR);
    push(OpR, 0, 0, 0, EWbAlu);
    push(OpLd, 0, 0, 1, EIfRdy);
    push(OpLd, 0, 0, 0, EId);
    push(OpLd, 0, 0, 0, EExMem);
    push(OpLd, 0, 0, 0, EMemLd);
    push(OpLd, 0, 0, 0, EMemLd);
    push(OpLd, 0, 0, 1, EMemLd);
    push(OpLd, 0, 0, 0, EWbMdr);
    push(OpI, 0, 0, 1, EIfRdy);
    push(OpI, 0, 0, 0, EId);
    push(OpI, 0, 0, 0, EExI);
    push(OpI, 0, 0, 0, EWbAlu);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL back_to_back cycle %0d got %b want %b", n, obs, e);
      end
      n++;
      @(posedge clk);
      #1;
    end
    exp_retired += 3;
    checks++;
    if (bus.retired !== exp_retired) begin
      errors++;
      $display("FAIL back_to_back_retired got %0d want %0d", bus.retired, exp_retired);
    end
  endtask

  task automatic test_branch();
    stim_t s;
    logic [13:0] e;
    int n = 0;
    push(OpBr, 0, 0, 1, EIfRdy);
    push(OpBr, 1, 0, 0, EId);
    push(OpBr, 0, 0, 0, EExBrNt);
    push(OpBr, 0, 0, 1, EIfRdy);
    push(OpBr, 0, 0, 0, EId);
    push(OpBr, 1, 0, 0, EExBrT);
    push(OpBr, 0, 0, 0, EBr);
    push(OpBr, 0, 0, 0, EIfWait);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL branch cycle %0d got %b want %b", n, obs, e);
      end
      n++;
      @(posedge clk);
      #1;
    end
    exp_retired += 2;
    checks++;
    if (bus.retired !== exp_retired) begin
      errors++;
      $display("FAIL branch_retired got %0d want %0d", bus.retired, exp_retired);
    end
  endtask

  task automatic test_jump_store();
    stim_t s;
    logic [13:0] e;
    int n = 0;
    push(OpJalr, 0, 0, 0, EIfWait);
    push(OpJalr, 0, 0, 1, EIfRdy);
    push(OpJalr, 0, 0, 0, EId);
    push(OpJalr, 0, 0, 0, EExJalr);
    push(OpJal, 0, 0, 1, EIfRdy);
    push(OpJal, 0, 0, 0, EId);
    push(OpJal, 0, 0, 1, EExJal);
    push(OpSt, 0, 0, 1, EIfRdy);
    push(OpSt, 0, 0, 0, EId);
    push(OpSt, 0, 0, 0, EExMem);
    push(OpSt, 0, 0, 0, EMemStWait);
    push(OpSt, 0, 0, 1, EMemStRdy);
    push(OpSt, 0, 0, 0, EIfWait);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL jump_store cycle %0d got %b want %b", n, obs, e);
      end
      n++;
      @(posedge clk);
      #1;
    end
    exp_retired += 3;
    checks++;
    if (bus.retired !== exp_retired) begin
      errors++;
      $display("FAIL jump_store_retired got %0d want %0d", bus.retired, exp_retired);
    end
  endtask

  task automatic test_ecall_nohalt();
    stim_t s;
    logic [13:0] e;
    int n = 0;
    push(OpSys, 0, 0, 1, EIfRdy);
    push(OpSys, 0, 0, 0, EIdSkip);
    push(OpLui, 0, 1, 1, EIfRdy);
    push(OpLui, 0, 1, 0, EIdSkip);  // unknown opcode retires from ID even with halt_req
    push(OpR, 0, 0, 0, EIfWait);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ecall_nohalt cycle %0d got %b want %b", n, obs, e);
      end
      n++;
      @(posedge clk);
      #1;
    end
    exp_retired += 2;
    checks++;
    if (bus.retired !== exp_retired) begin
      errors++;
      $display("FAIL ecall_nohalt_retired got %0d want %0d", bus.retired, exp_retired);
    end
  endtask

  task automatic test_reset_mid_ex();
    stim_t s;
    logic [13:0] e;
    int n = 0;
    push(OpR, 0, 0, 1, EIfRdy);
    push(OpR, 0, 0, 0, EId);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid_ex cycle %0d got %b want %b", n, obs, e);
      end
      n++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (obs !== EExR) begin
      errors++;
      $display("FAIL reset_mid_ex_in_ex got %b want %b", obs, EExR);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== EIfWait) begin
      errors++;
      $display("FAIL reset_mid_ex_outputs got %b want %b", obs, EIfWait);
    end
    checks++;
    if (bus.retired !== '0) begin
      errors++;
      $display("FAIL reset_mid_ex_retired got %0d want 0", bus.retired);
    end
    exp_retired = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ecall_halt();
    stim_t s;
    logic [13:0] e;
    int n = 0;
    push(OpSys, 0, 1, 1, EIfRdy);
    push(OpSys, 0, 1, 0, EId);
    push(OpSys, 0, 1, 1, EHalt);
    push(OpLd, 1, 0, 1, EHalt);
    push(OpSt, 0, 0, 0, EHalt);
    push(OpJal, 1, 1, 1, EHalt);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ecall_halt cycle %0d got %b want %b", n, obs, e);
      end
      n++;
      @(posedge clk);
      #1;
    end
    exp_retired += 1;
    checks++;
    if (bus.retired !== exp_retired) begin
      errors++;
      $display("FAIL ecall_halt_retired got %0d want %0d", bus.retired, exp_retired);
    end
    for (int i = 0; i < 4; i++) begin
      apply(stim_t'{OpR, 1'b0, 1'b0, i[0]});
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus.retired !== exp_retired || bus.is_halted !== 1'b1) begin
      errors++;
      $display("FAIL ecall_halt_frozen got retired %0d halted %b want %0d 1",
               bus.retired, bus.is_halted, exp_retired);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_branch();
    test_jump_store();
    test_ecall_nohalt();
    test_reset_mid_ex();
    test_back_to_back();
    test_ecall_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
